mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Round-robin arbiter between the data cache's per-lane controller interface and the single external data-memory port. It accepts up to NUM_CONSUMERS independent read/write miss and eviction requests and serializes them one at a time onto the memory port. It returns read data and completion pulses to the originating lane. It sits directly downstream of the data cache, in place of a direct wire-up to memory.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width per transfer
- NUM_CONSUMERS, 8, number of request lanes from the cache (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- lane_read_valid  in  NUM_CONSUMERS  per-lane read request, level, held until serviced
- lane_read_address  in  ADDR_BITS×NUM_CONSUMERS  per-lane read address
- lane_read_ready  out  NUM_CONSUMERS  one-cycle completion pulse per lane
- lane_read_data  out  DATA_BITS×NUM_CONSUMERS  read data; valid while the matching ready is high, held afterwards
- lane_write_valid  in  NUM_CONSUMERS  per-lane write-back request, level
- lane_write_address  in  ADDR_BITS×NUM_CONSUMERS  per-lane write address
- lane_write_data  in  DATA_BITS×NUM_CONSUMERS  per-lane write data
- lane_write_ready  out  NUM_CONSUMERS  one-cycle completion pulse per lane
- mem_read_valid  out  1  memory read request, held until mem_read_ready
- mem_read_address  out  ADDR_BITS  memory read address
- mem_read_ready  in  1  memory read completion; mem_read_data valid this cycle
- mem_read_data  in  DATA_BITS  memory read data
- mem_write_valid  out  1  memory write request, held until mem_write_ready
- mem_write_address  out  ADDR_BITS  memory write address
- mem_write_data  out  DATA_BITS  memory write data
- mem_write_ready  in  1  memory write completion

## Operation
- Registered state: FSM state, grant index `gnt` ($clog2(NUM_CONSUMERS) bits), round-robin pointer `rr`, and latched address/data/op.
- FSM states are IDLE, READ_WAITING, WRITE_WAITING and RELAYING.
- IDLE:
  - Scan lanes rr, rr+1, … modulo NUM_CONSUMERS. The first lane with read_valid or write_valid wins.
  - Within a lane, a write beats a read, so an eviction always reaches memory before the refill.
  - On a win: latch gnt, address, and data (for a write); assert mem_write_valid or mem_read_valid; go to WRITE_WAITING or READ_WAITING.
  - With no request, stay in IDLE with all outputs low.
- READ_WAITING: hold mem_read_valid and address. On mem_read_ready:
  - drop mem_read_valid;
  - pulse lane_read_ready[gnt];
  - load lane_read_data[gnt] with mem_read_data;
  - go to RELAYING.
- WRITE_WAITING: hold mem_write_valid, address and data. On mem_write_ready: drop mem_write_valid, pulse lane_write_ready[gnt], go to RELAYING.
- RELAYING:
  - Stay until the serviced op's valid on lane gnt is low; the other op's valid on that lane is ignored.
  - Then set rr = gnt+1 (wrap to 0 after NUM_CONSUMERS-1) and go to IDLE.
  - This prevents re-issuing a request that the cache has not yet withdrawn.
- At most one memory transaction is outstanding. mem_read_valid and mem_write_valid are never high together.
- Lane inputs are sampled only in IDLE. Changes on the granted lane during the WAITING states are ignored because the latched copy is used.
- A lane's read_data holds its last value until that lane's next read completes.
- If mem_*_ready arrives while the matching mem_*_valid is low, it is ignored.

## Timing
- Reset is asynchronous: when reset goes low, on that edge and without waiting for clk:
  - every output goes to 0 (valids, readies, addresses, data, all lane_read_data);
  - state goes to IDLE, rr to 0, gnt to 0.
- Reset mid-transaction abandons the transaction: no lane ready pulse is issued, and mem valid drops immediately.
- Leaving reset: the first clk edge with reset high may grant a request.
- Latency:
  - Request visible at edge 0 (IDLE) → mem valid high after edge 0.
  - mem ready sampled at edge k → lane ready high for exactly the cycle after edge k; mem valid low in that same cycle.
  - Minimum request-to-ready latency is 2 cycles, when memory responds in the first valid cycle.
- Minimum turnaround is 1 RELAYING cycle. The lane's valid falling at the same edge as the ready pulse gives IDLE on the next edge, so back-to-back grants are 3 cycles apart at best.
- Fairness: a continuously requesting lane waits at most NUM_CONSUMERS-1 grants.

## Test plan
- Single read:
  - Stimulus: reset then release; lane 2 reads 0x3C; memory returns 0xA5 with ready one cycle after mem_read_valid.
  - Required response: mem_read_address = 0x3C; lane_read_ready = 8'b0000_0100 for exactly one cycle with lane_read_data[2] = 0xA5; no other lane strobes.
- Write-before-read on the same lane:
  - Stimulus: lane 5 asserts write 0x10/0x77 and read 0x20 together.
  - Required response: the memory write (0x10, 0x77) completes first, then the read of 0x20, with no overlap of the mem valids.
- Round-robin:
  - Stimulus: lanes 0, 3 and 7 request reads simultaneously and hold until served.
  - Required response: grants in order 0, 3, 7. If lane 0 re-requests after its service, its next grant comes after lane 7.
- Stalled memory:
  - Stimulus: mem_read_ready held low for 20 cycles; lane 1's address changes during the stall.
  - Required response: mem_read_valid and the original address stay stable throughout; the completion goes only to lane 1.
- Asynchronous reset mid-transaction:
  - Stimulus: reset driven low between clock edges during WRITE_WAITING.
  - Required response: mem_write_valid and all outputs go to 0 before the next edge; after release, pending requests are re-granted starting from lane 0.
- Slow withdrawal:
  - Stimulus: lane 4 holds read_valid 3 cycles past its ready pulse.
  - Required response: the arbiter stays in RELAYING; there is no second memory read and no second ready pulse.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Round-robin arbiter that serializes per-lane cache read/write requests onto
// a single external data-memory port, one transaction at a time, and returns
// completion pulses and read data to the originating lane.

module mem_req_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic [NUM_CONSUMERS-1:0]           lane_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] lane_read_address,
  output logic [NUM_CONSUMERS-1:0]           lane_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0] lane_read_data,

  input  logic [NUM_CONSUMERS-1:0]           lane_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] lane_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0] lane_write_data,
  output logic [NUM_CONSUMERS-1:0]           lane_write_ready,

  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,

  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int GNT_BITS = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    RELAYING
  } state_t;

  state_t state;
  state_t state_next;

  logic [GNT_BITS-1:0]  gnt;
  logic [GNT_BITS-1:0]  rr;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 op_write_q;

  logic [GNT_BITS-1:0]  win_idx;
  logic                 win_found;
  logic                 win_is_write;
  logic [GNT_BITS:0]    scan_sum;
  logic [GNT_BITS-1:0]  scan_lane;
  logic                 relay_valid;

  logic [ADDR_BITS-1:0] rd_addr_arr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_arr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_arr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rdata_q     [NUM_CONSUMERS];

  // Flattened lane buses viewed as per-lane arrays so a lane can be picked by index
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
    assign rd_addr_arr[g] = lane_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_arr[g] = lane_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_arr[g] = lane_write_data[g*DATA_BITS +: DATA_BITS];
    assign lane_read_data[g*DATA_BITS +: DATA_BITS] = rdata_q[g];
  end

  // Round-robin scan starting at rr; first lane with any request wins, write before read
  always_comb begin
    win_found    = 1'b0;
    win_idx      = '0;
    win_is_write = 1'b0;
    scan_sum     = '0;
    scan_lane    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan_sum = {1'b0, rr} + (GNT_BITS+1)'(i);
      if (scan_sum >= (GNT_BITS+1)'(NUM_CONSUMERS)) begin
        scan_sum = scan_sum - (GNT_BITS+1)'(NUM_CONSUMERS);
      end
      scan_lane = scan_sum[GNT_BITS-1:0];
      if (!win_found && (lane_read_valid[scan_lane] || lane_write_valid[scan_lane])) begin
        win_found    = 1'b1;
        win_idx      = scan_lane;
        win_is_write = lane_write_valid[scan_lane];
      end
    end
  end

  // Only the serviced op's valid on the granted lane holds us in RELAYING
  assign relay_valid = op_write_q ? lane_write_valid[gnt] : lane_read_valid[gnt];

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and memory-side outputs, which are zero outside the WAITING states
  always_comb begin
    state_next        = state;
    mem_read_valid    = 1'b0;
    mem_read_address  = '0;
    mem_write_valid   = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = win_is_write ? WRITE_WAITING : READ_WAITING;
        end
      end
      READ_WAITING: begin
        mem_read_valid   = 1'b1;
        mem_read_address = addr_q;
        if (mem_read_ready) begin
          state_next = RELAYING;
        end
      end
      WRITE_WAITING: begin
        mem_write_valid   = 1'b1;
        mem_write_address = addr_q;
        mem_write_data    = data_q;
        if (mem_write_ready) begin
          state_next = RELAYING;
        end
      end
      RELAYING: begin
        if (!relay_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant bookkeeping, latched request, lane completion pulses and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt              <= '0;
      rr               <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      op_write_q       <= 1'b0;
      lane_read_ready  <= '0;
      lane_write_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      lane_read_ready  <= '0;
      lane_write_ready <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt        <= win_idx;
            op_write_q <= win_is_write;
            addr_q     <= win_is_write ? wr_addr_arr[win_idx] : rd_addr_arr[win_idx];
            data_q     <= win_is_write ? wr_data_arr[win_idx] : '0;
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            lane_read_ready[gnt] <= 1'b1;
            rdata_q[gnt]         <= mem_read_data;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            lane_write_ready[gnt] <= 1'b1;
          end
        end
        RELAYING: begin
          if (!relay_valid) begin
            rr <= (gnt == GNT_BITS'(NUM_CONSUMERS-1)) ? '0 : gnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Only one memory transaction may be outstanding at a time
  a_one_outstanding: assert property (@(posedge clk) disable iff (!reset)
    !(mem_read_valid && mem_write_valid));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
// Directed scenarios for mem_req_arbiter with hand-computed expected values.

module tb_mem_req_arbiter;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     lane_read_valid;
  logic [AB*NC-1:0]  lane_read_address;
  logic [NC-1:0]     lane_read_ready;
  logic [DB*NC-1:0]  lane_read_data;
  logic [NC-1:0]     lane_write_valid;
  logic [AB*NC-1:0]  lane_write_address;
  logic [DB*NC-1:0]  lane_write_data;
  logic [NC-1:0]     lane_write_ready;
  logic              mem_read_valid;
  logic [AB-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DB-1:0]     mem_read_data;
  logic              mem_write_valid;
  logic [AB-1:0]     mem_write_address;
  logic [DB-1:0]     mem_write_data;
  logic              mem_write_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mem_req_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) dut (
    .clk                (clk),
    .reset              (reset),
    .lane_read_valid    (lane_read_valid),
    .lane_read_address  (lane_read_address),
    .lane_read_ready    (lane_read_ready),
    .lane_read_data     (lane_read_data),
    .lane_write_valid   (lane_write_valid),
    .lane_write_address (lane_write_address),
    .lane_write_data    (lane_write_data),
    .lane_write_ready   (lane_write_ready),
    .mem_read_valid     (mem_read_valid),
    .mem_read_address   (mem_read_address),
    .mem_read_ready     (mem_read_ready),
    .mem_read_data      (mem_read_data),
    .mem_write_valid    (mem_write_valid),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_write_ready    (mem_write_ready)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse used to re-seed the round-robin pointer
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset              = 1'b0;
    lane_read_valid    = '0;
    lane_read_address  = '0;
    lane_write_valid   = '0;
    lane_write_address = '0;
    lane_write_data    = '0;
    mem_read_ready     = 1'b0;
    mem_read_data      = '0;
    mem_write_ready    = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_read_valid: got %b, expected 0", mem_read_valid); end
    n_checks++; if (mem_write_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_write_valid: got %b, expected 0", mem_write_valid); end
    n_checks++; if (lane_read_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_lane_read_ready: got %b, expected 0", lane_read_ready); end
    n_checks++; if (lane_write_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_lane_write_ready: got %b, expected 0", lane_write_ready); end
    n_checks++; if (lane_read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_lane_read_data: got %h, expected 0", lane_read_data); end
    n_checks++; if ({mem_read_address, mem_write_address, mem_write_data} !== 24'h0) begin n_fail++; $display("[TB] FAIL rst_mem_addr_data: got %h, expected 0", {mem_read_address, mem_write_address, mem_write_data}); end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    lane_read_valid[2]           = 1'b1;
    lane_read_address[2*AB +: AB] = 8'h3C;
    tick();
    n_checks++; if (mem_read_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_mem_read_valid: got %b, expected 1", mem_read_valid); end
    n_checks++; if (mem_read_address !== 8'h3C) begin n_fail++; $display("[TB] FAIL single_mem_read_address: got %h, expected 3c", mem_read_address); end
    n_checks++; if (lane_read_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL single_early_ready: got %b, expected 0", lane_read_ready); end
    mem_read_ready = 1'b1;
    mem_read_data  = 8'hA5;
    tick();
    n_checks++; if (lane_read_ready !== 8'b0000_0100) begin n_fail++; $display("[TB] FAIL single_lane_read_ready: got %b, expected 00000100", lane_read_ready); end
    n_checks++; if (lane_read_data !== 64'h0000_0000_00A5_0000) begin n_fail++; $display("[TB] FAIL single_lane_read_data: got %h, expected 0000000000a50000", lane_read_data); end
    n_checks++; if (mem_read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_mem_valid_drop: got %b, expected 0", mem_read_valid); end
    mem_read_ready     = 1'b0;
    mem_read_data      = 8'hFF;
    lane_read_valid[2] = 1'b0;
    tick();
    n_checks++; if (lane_read_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL single_ready_one_cycle: got %b, expected 0", lane_read_ready); end
    n_checks++; if (lane_read_data[2*DB +: DB] !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_data_held: got %h, expected a5", lane_read_data[2*DB +: DB]); end
    tick();
    n_checks++; if (mem_read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle_quiet: got %b, expected 0", mem_read_valid); end
  endtask

  task automatic test_write_before_read();
    lane_write_valid[5]             = 1'b1;
    lane_write_address[5*AB +: AB]  = 8'h10;
    lane_write_data[5*DB +: DB]     = 8'h77;
    lane_read_valid[5]              = 1'b1;
    lane_read_address[5*AB +: AB]   = 8'h20;
    tick();
    n_checks++; if ({mem_write_valid, mem_read_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL wbr_write_first: got wv/rv %b, expected 10", {mem_write_valid, mem_read_valid}); end
    n_checks++; if ({mem_write_address, mem_write_data} !== 16'h1077) begin n_fail++; $display("[TB] FAIL wbr_write_addr_data: got %h, expected 1077", {mem_write_address, mem_write_data}); end
    mem_write_ready = 1'b1;
    tick();
    n_checks++; if (lane_write_ready !== 8'b0010_0000) begin n_fail++; $display("[TB] FAIL wbr_lane_write_ready: got %b, expected 00100000", lane_write_ready); end
    n_checks++; if ({mem_write_valid, mem_read_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL wbr_relay_quiet: got wv/rv %b, expected 00", {mem_write_valid, mem_read_valid}); end
    mem_write_ready     = 1'b0;
    lane_write_valid[5] = 1'b0;
    tick();
    n_checks++; if ({mem_write_valid, mem_read_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL wbr_no_overlap: got wv/rv %b, expected 00", {mem_write_valid, mem_read_valid}); end
    tick();
    n_checks++; if ({mem_write_valid, mem_read_valid} !== 2'b01) begin n_fail++; $display("[TB] FAIL wbr_read_second: got wv/rv %b, expected 01", {mem_write_valid, mem_read_valid}); end
    n_checks++; if (mem_read_address !== 8'h20) begin n_fail++; $display("[TB] FAIL wbr_read_addr: got %h, expected 20", mem_read_address); end
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h5A;
    tick();
    n_checks++; if (lane_read_ready !== 8'b0010_0000) begin n_fail++; $display("[TB] FAIL wbr_lane_read_ready: got %b, expected 00100000", lane_read_ready); end
    n_checks++; if (lane_read_data[5*DB +: DB] !== 8'h5A) begin n_fail++; $display("[TB] FAIL wbr_lane_read_data: got %h, expected 5a", lane_read_data[5*DB +: DB]); end
    mem_read_ready     = 1'b0;
    lane_read_valid[5] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    lane_write_valid[6]            = 1'b1;
    lane_write_address[6*AB +: AB] = 8'h66;
    lane_write_data[6*DB +: DB]    = 8'h12;
    lane_write_valid[1]            = 1'b1;
    lane_write_address[1*AB +: AB] = 8'h44;
    lane_write_data[1*DB +: DB]    = 8'h99;
    tick();
    n_checks++; if ({mem_write_valid, mem_write_address} !== 9'h166) begin n_fail++; $display("[TB] FAIL arst_grant_before: got %h, expected 166", {mem_write_valid, mem_write_address}); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (mem_write_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_write_valid_drop: got %b, expected 0", mem_write_valid); end
    n_checks++; if ({mem_write_address, mem_write_data} !== 16'h0) begin n_fail++; $display("[TB] FAIL arst_write_addr_data: got %h, expected 0", {mem_write_address, mem_write_data}); end
    n_checks++; if (lane_read_data !== 64'h0) begin n_fail++; $display("[TB] FAIL arst_lane_read_data: got %h, expected 0", lane_read_data); end
    mem_write_ready = 1'b1;
    tick();
    n_checks++; if (lane_write_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL arst_no_ready_pulse: got %b, expected 0", lane_write_ready); end
    mem_write_ready = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++; if ({mem_write_valid, mem_write_address, mem_write_data} !== 17'h1_4499) begin n_fail++; $display("[TB] FAIL arst_regrant_lane1: got %h, expected 14499", {mem_write_valid, mem_write_address, mem_write_data}); end
    mem_write_ready = 1'b1;
    tick();
    n_checks++; if (lane_write_ready !== 8'b0000_0010) begin n_fail++; $display("[TB] FAIL arst_lane1_ready: got %b, expected 00000010", lane_write_ready); end
    mem_write_ready     = 1'b0;
    lane_write_valid[1] = 1'b0;
    tick();
    tick();
    n_checks++; if ({mem_write_valid, mem_write_address} !== 9'h166) begin n_fail++; $display("[TB] FAIL arst_regrant_lane6: got %h, expected 166", {mem_write_valid, mem_write_address}); end
    mem_write_ready = 1'b1;
    tick();
    n_checks++; if (lane_write_ready !== 8'b0100_0000) begin n_fail++; $display("[TB] FAIL arst_lane6_ready: got %b, expected 01000000", lane_write_ready); end
    mem_write_ready     = 1'b0;
    lane_write_valid[6] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int order [4];
    order = '{0, 3, 7, 0};
    do_reset();
    lane_read_address[0*AB +: AB] = 8'h80;
    lane_read_address[3*AB +: AB] = 8'h83;
    lane_read_address[7*AB +: AB] = 8'h87;
    lane_read_valid[0] = 1'b1;
    lane_read_valid[3] = 1'b1;
    lane_read_valid[7] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if ({mem_read_valid, mem_read_address} !== {1'b1, 8'h80 + 8'(order[k])}) begin n_fail++; $display("[TB] FAIL rr_grant%0d: got %h, expected %h", k, {mem_read_valid, mem_read_address}, {1'b1, 8'h80 + 8'(order[k])}); end
      mem_read_ready = 1'b1;
      mem_read_data  = 8'hC0 + 8'(order[k]);
      tick();
      n_checks++; if (lane_read_ready !== 8'(1 << order[k])) begin n_fail++; $display("[TB] FAIL rr_ready%0d: got %b, expected %b", k, lane_read_ready, 8'(1 << order[k])); end
      mem_read_ready = 1'b0;
      lane_read_valid[order[k]] = 1'b0;
      tick();
      if (k == 0) lane_read_valid[0] = 1'b1;
    end
    n_checks++; if (lane_read_data !== 64'hC700_0000_C300_00C0) begin n_fail++; $display("[TB] FAIL rr_lane_data: got %h, expected c7000000c30000c0", lane_read_data); end
  endtask

  task automatic test_stalled_memory();
    lane_read_address[1*AB +: AB] = 8'h11;
    lane_read_valid[1] = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c == 5) lane_read_address[1*AB +: AB] = 8'hEE;
      tick();
      n_checks++; if ({mem_read_valid, mem_read_address} !== 9'h111) begin n_fail++; $display("[TB] FAIL stall_hold_c%0d: got %h, expected 111", c, {mem_read_valid, mem_read_address}); end
      n_checks++; if (lane_read_ready !== 8'h00) begin n_fail++; $display("[TB] FAIL stall_no_ready_c%0d: got %b, expected 0", c, lane_read_ready); end
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h3E;
    tick();
    n_checks++; if (lane_read_ready !== 8'b0000_0010) begin n_fail++; $display("[TB] FAIL stall_ready_lane1: got %b, expected 00000010", lane_read_ready); end
    n_checks++; if (lane_read_data[1*DB +: DB] !== 8'h3E) begin n_fail++; $display("[TB] FAIL stall_data_lane1: got %h, expected 3e", lane_read_data[1*DB +: DB]); end
    mem_read_ready     = 1'b0;
    lane_read_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_slow_withdrawal();
    lane_read_address[4*AB +: AB] = 8'h44;
    lane_read_valid[4] = 1'b1;
    tick();
    n_checks++; if ({mem_read_valid, mem_read_address} !== 9'h144) begin n_fail++; $display("[TB] FAIL slow_grant: got %h, expected 144", {mem_read_valid, mem_read_address}); end
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h4D;
    tick();
    n_checks++; if (lane_read_ready !== 8'b0001_0000) begin n_fail++; $display("[TB] FAIL slow_ready: got %b, expected 00010000", lane_read_ready); end
    mem_read_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hFF;
      end
      tick();
      n_checks++; if ({mem_read_valid, lane_read_ready} !== 9'h0) begin n_fail++; $display("[TB] FAIL slow_hold_c%0d: got %h, expected 0", c, {mem_read_valid, lane_read_ready}); end
    end
    mem_read_ready     = 1'b0;
    lane_read_valid[4] = 1'b0;
    tick();
    tick();
    n_checks++; if ({mem_read_valid, lane_read_ready} !== 9'h0) begin n_fail++; $display("[TB] FAIL slow_no_reissue: got %h, expected 0", {mem_read_valid, lane_read_ready}); end
    n_checks++; if (lane_read_data[4*DB +: DB] !== 8'h4D) begin n_fail++; $display("[TB] FAIL slow_data_held: got %h, expected 4d", lane_read_data[4*DB +: DB]); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_read();
    test_write_before_read();
    test_async_reset();
    test_round_robin();
    test_stalled_memory();
    test_slow_withdrawal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
